// File: rtl/load_store_unit_if.sv
// Memory-side bus of the load/store unit.
// The LSU drives requests as master; memory answers as slave.
interface load_store_unit_if #(
  parameter int Width = 32
);
  logic             Bus_Req;
  logic             Bus_We;
  logic [Width-1:0] Bus_Addr;
  logic [Width-1:0] Bus_WData;
  logic [3:0]       Bus_WStrb;
  logic             Bus_Ready;
  logic [Width-1:0] Bus_RData;

  modport master (
    output Bus_Req, Bus_We, Bus_Addr,
    output Bus_WData, Bus_WStrb,
    input  Bus_Ready, Bus_RData
  );

  modport slave (
    input  Bus_Req, Bus_We, Bus_Addr,
    input  Bus_WData, Bus_WStrb,
    output Bus_Ready, Bus_RData
  );
endinterface

// File: rtl/load_store_unit.sv
// Load/store unit: stalls the core, runs one bus access,
// formats stores, extends loads and times out a silent bus.
module load_store_unit #(
  parameter int Width   = 32,
  parameter int TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [Width-1:0] Address,
  input  logic [Width-1:0] Store_Data,
  input  logic             Mem_Read,
  input  logic             Mem_Write,
  input  logic [2:0]       Funct3,
  output logic [Width-1:0] Load_Data,
  output logic             Stall,
  output logic             Fault,
  load_store_unit_if.master bus
);
  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  state_t           state, state_next;
  logic [CW-1:0]    count;
  logic [Width-1:0] addr_q, wdata_q;
  logic [3:0]       strb_q;
  logic [2:0]       f3_q;
  logic             we_q, timeout_q;

  logic             req, is_store;
  logic             f3_ok, align_ok, legal;
  logic [3:0]       strb_d;
  logic [Width-1:0] wdata_d;
  logic             start, ready_hit, timeout_hit;

  function automatic logic [Width-1:0] extract(
    input logic [Width-1:0] d,
    input logic [1:0]       off,
    input logic [2:0]       f3
  );
    logic [Width-1:0] s;
    logic [Width-1:0] r;
    s = d >> {off, 3'b000};
    unique case (f3)
      3'b000:  r = {{(Width-8){s[7]}}, s[7:0]};
      3'b001:  r = {{(Width-16){s[15]}}, s[15:0]};
      3'b100:  r = {{(Width-8){1'b0}}, s[7:0]};
      3'b101:  r = {{(Width-16){1'b0}}, s[15:0]};
      default: r = d;
    endcase
    return r;
  endfunction

  // Request decode: legality and store formatting; a store wins over a load.
  always_comb begin
    is_store = Mem_Write;
    req      = Mem_Read | Mem_Write;
    unique case (Funct3)
      3'b000, 3'b001, 3'b010: f3_ok = 1'b1;
      3'b100, 3'b101:         f3_ok = !is_store;
      default:                f3_ok = 1'b0;
    endcase
    align_ok = 1'b1;
    if (Funct3[1:0] == 2'b01) align_ok = !Address[0];
    if (Funct3[1:0] == 2'b10) align_ok = (Address[1:0] == 2'b00);
    legal   = f3_ok & align_ok;
    strb_d  = 4'b0000;
    wdata_d = Store_Data;
    if (is_store) begin
      unique case (Funct3[1:0])
        2'b00: begin
          strb_d  = 4'b0001 << Address[1:0];
          wdata_d = {4{Store_Data[7:0]}};
        end
        2'b01: begin
          strb_d  = 4'b0011 << Address[1:0];
          wdata_d = {2{Store_Data[15:0]}};
        end
        default: strb_d = 4'b1111;
      endcase
    end
  end

  // Next state plus the combinational Stall/Fault handshake to the core.
  always_comb begin
    state_next  = state;
    Stall       = 1'b0;
    Fault       = 1'b0;
    start       = 1'b0;
    ready_hit   = 1'b0;
    timeout_hit = 1'b0;
    unique case (state)
      IDLE: begin
        if (req) begin
          if (legal) begin
            Stall      = 1'b1;
            start      = 1'b1;
            state_next = WAIT;
          end else begin
            Fault = 1'b1;
          end
        end
      end
      WAIT: begin
        Stall = 1'b1;
        if (bus.Bus_Ready) begin
          ready_hit  = 1'b1;
          state_next = DONE;
        end else if (count == CW'(TIMEOUT - 1)) begin
          timeout_hit = 1'b1;
          state_next  = DONE;
        end
      end
      DONE: begin
        Fault      = timeout_q;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // State register; reset forces IDLE so Bus_Req drops at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Latched access, wait counter, timeout flag and load result.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_q    <= '0;
      wdata_q   <= '0;
      strb_q    <= '0;
      f3_q      <= '0;
      we_q      <= 1'b0;
      timeout_q <= 1'b0;
      count     <= '0;
      Load_Data <= '0;
    end else begin
      if (start) begin
        addr_q    <= Address;
        wdata_q   <= wdata_d;
        strb_q    <= strb_d;
        f3_q      <= Funct3;
        we_q      <= is_store;
        timeout_q <= 1'b0;
        count     <= '0;
      end
      if (state == WAIT && !ready_hit && !timeout_hit)
        count <= count + 1'b1;
      if (ready_hit && !we_q)
        Load_Data <= extract(bus.Bus_RData, addr_q[1:0], f3_q);
      if (timeout_hit) begin
        Load_Data <= '0;
        timeout_q <= 1'b1;
      end
      if (state == DONE) begin
        timeout_q <= 1'b0;
        count     <= '0;
      end
    end
  end

  assign bus.Bus_Req   = (state == WAIT);
  assign bus.Bus_We    = (state == WAIT) & we_q;
  assign bus.Bus_Addr  = {addr_q[Width-1:2], 2'b00};
  assign bus.Bus_WData = wdata_q;
  assign bus.Bus_WStrb = strb_q;
endmodule
